// File: rtl/as6d_pcs_pldb_pkg.sv
// ----------------------------------------------------------------------------
// as6d_pcs_pldb_pkg
// Shared definitions for the PCS payload-buffer (PLDB) write-side controller:
// the FSM state encoding and the default beat width.
// ----------------------------------------------------------------------------
package as6d_pcs_pldb_pkg;

  // Default beat width of the payload buffer.
  localparam int PLDB_DATA_WIDTH = 72;

  // RUN   : upstream enabled, skid draining into the FIFO.
  // STALL : in_rdy withdrawn because the skid or the FIFO is filling up.
  // FLUSH : skid discarded, drain halted, inbound beats dropped silently.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } pldb_state_e;

endpackage : as6d_pcs_pldb_pkg

// File: rtl/as6d_pcs_tx_pldb_wr_skid_ctrl_if.sv
// ----------------------------------------------------------------------------
// as6d_pcs_tx_pldb_wr_skid_ctrl_if
// Bundles the upstream valid/ready beat link and the FIFO write port seen by
// the write-side skid controller.
//   slave  : controller view (consumes upstream beats, drives FIFO write port)
//   master : environment view (issues upstream beats, models the FIFO)
// Signals:
//   in_data/in_val   upstream beat and its valid
//   in_rdy           registered ready back to upstream
//   fifo_wr_data/_en FIFO write port
//   fifo_full        FIFO full (blocks the drain)
//   fifo_prog_full   FIFO programmable-full (forces a stall)
// ----------------------------------------------------------------------------
interface as6d_pcs_tx_pldb_wr_skid_ctrl_if
  import as6d_pcs_pldb_pkg::*;
#(
  parameter int DATA_WIDTH = PLDB_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_val;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_wr_en;
  logic                  fifo_full;
  logic                  fifo_prog_full;

  modport slave (
    input  in_data, in_val, fifo_full, fifo_prog_full,
    output in_rdy, fifo_wr_data, fifo_wr_en
  );

  modport master (
    output in_data, in_val, fifo_full, fifo_prog_full,
    input  in_rdy, fifo_wr_data, fifo_wr_en
  );
endinterface : as6d_pcs_tx_pldb_wr_skid_ctrl_if

// File: rtl/as6d_pcs_tx_pldb_skid_regfile.sv
// ----------------------------------------------------------------------------
// as6d_pcs_tx_pldb_skid_regfile
// Skid storage: DEPTH x DATA_WIDTH flop array, one synchronous write port and
// one asynchronous (combinational) read port.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational from raddr_i)
// ----------------------------------------------------------------------------
module as6d_pcs_tx_pldb_skid_regfile #(
  parameter int DATA_WIDTH = 72,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; an entry is only ever read after it has been
  // written, so resetting it would cost a reset net on every data flop for no
  // functional gain.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : as6d_pcs_tx_pldb_skid_regfile

// File: rtl/as6d_pcs_tx_pldb_wr_skid_ctrl.sv
// ----------------------------------------------------------------------------
// as6d_pcs_tx_pldb_wr_skid_ctrl
// Write-side controller for the PCS TX payload-buffer sync FIFO. Every upstream
// beat lands in a small skid buffer, which drains into the FIFO write port
// whenever the FIFO is not full. in_rdy is withdrawn early enough that the
// beats still in flight (RDY_LAT+1) always fit, so a legal upstream never
// loses data. A software flush discards everything; a beat that finds no room
// is dropped and reported on ovf_int.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       level; discard skid contents and inbound beats
//   bus         upstream link + FIFO write port (slave modport)
//   skid_cnt    skid occupancy
//   stall_sts   1 while the FSM is in STALL
//   ovf_int     1-cycle pulse for each dropped beat
// ----------------------------------------------------------------------------
module as6d_pcs_tx_pldb_wr_skid_ctrl
  import as6d_pcs_pldb_pkg::*;
#(
  parameter int DATA_WIDTH = PLDB_DATA_WIDTH,
  parameter int SKID_DEPTH = 8,
  parameter int RDY_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  as6d_pcs_tx_pldb_wr_skid_ctrl_if.slave bus,
  output logic [$clog2(SKID_DEPTH):0]   skid_cnt,
  output logic                          stall_sts,
  output logic                          ovf_int
);

  localparam int PTR_W  = $clog2(SKID_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FCNT_W = $clog2(RDY_LAT + 1) + 1;

  // Stall early enough that RDY_LAT+1 in-flight beats still fit; resume only
  // at half occupancy so in_rdy does not chatter.
  localparam logic [CNT_W-1:0] STALL_ON  = CNT_W'(SKID_DEPTH - RDY_LAT - 1);
  localparam logic [CNT_W-1:0] STALL_OFF = CNT_W'(SKID_DEPTH / 2);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(SKID_DEPTH);

  pldb_state_e         state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                in_rdy_q;
  logic                ovf_q;

  logic                flush_act;
  logic                push;
  logic                pop;
  logic                drop;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [DATA_WIDTH-1:0] rd_data;

  // Inbound beats are discarded both in the cycle flush is raised and for the
  // whole FLUSH period; such discards are silent, not overflows.
  assign flush_act = flush | (state_q == ST_FLUSH);
  assign pop       = (cnt_q != '0) & ~bus.fifo_full & (state_q != ST_FLUSH);
  // A full skid can still accept a beat when one leaves in the same cycle.
  assign push      = bus.in_val & ~flush_act & ((cnt_q < DEPTH_C) | pop);
  assign drop      = bus.in_val & ~push & ~flush_act;
  assign cnt_nxt   = cnt_q + CNT_W'(push) - CNT_W'(pop);

  as6d_pcs_tx_pldb_skid_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_regfile (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_nxt;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (flush) begin
      // Flush wins over every other transition and empties the skid.
      state_d     = ST_FLUSH;
      flush_cnt_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.fifo_prog_full || (cnt_nxt >= STALL_ON)) state_d = ST_STALL;
        end
        ST_STALL: begin
          if (!bus.fifo_prog_full && (cnt_nxt < STALL_OFF)) state_d = ST_RUN;
        end
        ST_FLUSH: begin
          // Hold off RDY_LAT+1 cycles after deassert so beats launched under
          // the old in_rdy are swallowed here rather than stored.
          if (flush_cnt_q == FCNT_W'(RDY_LAT)) begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + FCNT_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      in_rdy_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      in_rdy_q    <= (state_d == ST_RUN);
      ovf_q       <= drop;
    end
  end

  assign bus.in_rdy       = in_rdy_q;
  assign bus.fifo_wr_en   = pop;
  assign bus.fifo_wr_data = rd_data;
  assign skid_cnt         = cnt_q;
  assign stall_sts        = (state_q == ST_STALL);
  assign ovf_int          = ovf_q;

endmodule : as6d_pcs_tx_pldb_wr_skid_ctrl

// File: tb/tb_as6d_pcs_tx_pldb_wr_skid_ctrl.sv
// ----------------------------------------------------------------------------
// tb_as6d_pcs_tx_pldb_wr_skid_ctrl
// Directed self-checking bench for the PLDB write-side skid controller.
// Inputs are driven just after the falling edge, outputs are sampled 1 time
// unit later, well away from the rising edge. A queue holds the beats expected
// on the FIFO write port, in order.
// ----------------------------------------------------------------------------
module tb_as6d_pcs_tx_pldb_wr_skid_ctrl;
  import as6d_pcs_pldb_pkg::*;

  localparam int DW = PLDB_DATA_WIDTH;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] skid_cnt;
  logic       stall_sts;
  logic       ovf_int;

  as6d_pcs_tx_pldb_wr_skid_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  as6d_pcs_tx_pldb_wr_skid_ctrl #(
    .DATA_WIDTH (DW),
    .SKID_DEPTH (8),
    .RDY_LAT    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .skid_cnt  (skid_cnt),
    .stall_sts (stall_sts),
    .ovf_int   (ovf_int)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];
  logic          r0, r1, r2;   // in_rdy seen this cycle, 1 and 2 cycles ago
  logic          exp_ovf;

  // Hand-computed occupancy / ready for the fifo_full stall scenario
  // (15 cycles of fifo_full with a legal upstream, then a free drain).
  int exp_cnt2 [23] = '{0,1,2,3,4,5,6,7,7,7,7,7,7,7,7,7,6,5,4,3,2,1,0};
  int exp_rdy2 [23] = '{1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,1};

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    r2 = r1;
    r1 = r0;
    r0 = bus.in_rdy;
  endtask

  task automatic drive(input logic val, input logic [DW-1:0] data,
                       input logic keep);
    bus.in_val  = val;
    bus.in_data = data;
    if (val && keep) exp_q.push_back(data);
  endtask

  // Settle, then score the FIFO write port and the overflow pulse.
  task automatic cyc_end();
    #1;
    if (exp_q.size() == 0)
      check("wr_en_idle", DW'(bus.fifo_wr_en), '0);
    else if (bus.fifo_wr_en === 1'b1)
      check("wr_data", bus.fifo_wr_data, exp_q.pop_front());
    check("ovf_int", DW'(ovf_int), DW'(exp_ovf));
  endtask

  task automatic idle();
    cyc_begin();
    drive(1'b0, '0, 1'b0);
    cyc_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_val = 1'b0;
    bus.in_data = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_prog_full = 1'b0;
    exp_ovf = 1'b0;
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;

    // ---- reset values ----
    #2;
    check("rst_in_rdy", DW'(bus.in_rdy), '0);
    check("rst_skid_cnt", DW'(skid_cnt), '0);
    check("rst_stall", DW'(stall_sts), '0);
    check("rst_ovf", DW'(ovf_int), '0);
    check("rst_wr_en", DW'(bus.fifo_wr_en), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_at_release", DW'(bus.in_rdy), '0);
    idle();
    check("rdy_1cyc_after_release", DW'(bus.in_rdy), 1);
    repeat (3) idle();

    // ---- 1: stream, no backpressure ----
    for (int i = 1; i <= 20; i++) begin
      cyc_begin();
      drive(1'b1, DW'(i), 1'b1);
      cyc_end();
      check("t1_wr_en", DW'(bus.fifo_wr_en), DW'(i > 1));
      check("t1_cnt", DW'(skid_cnt), DW'(i > 1));
      check("t1_rdy", DW'(bus.in_rdy), 1);
    end
    idle();
    check("t1_last_wr_en", DW'(bus.fifo_wr_en), 1);
    check("t1_last_cnt", DW'(skid_cnt), 1);
    idle();
    check("t1_empty_cnt", DW'(skid_cnt), '0);
    check("t1_sb_drained", DW'(exp_q.size()), '0);
    repeat (2) idle();

    // ---- 2: fifo_full stall with a legal upstream, then drain ----
    for (int k = 0; k < 23; k++) begin
      cyc_begin();
      bus.fifo_full = (k < 15);
      drive((k < 15) && r2, DW'(32'h100 + k), 1'b1);
      cyc_end();
      check("t2_cnt", DW'(skid_cnt), DW'(exp_cnt2[k]));
      check("t2_rdy", DW'(bus.in_rdy), DW'(exp_rdy2[k]));
      check("t2_stall", DW'(stall_sts), DW'(exp_rdy2[k] == 0));
      check("t2_wr_en", DW'(bus.fifo_wr_en), DW'((k >= 15) && (k <= 21)));
      check("t2_peak", DW'(skid_cnt <= 4'd8), 1);
    end
    check("t2_sb_drained", DW'(exp_q.size()), '0);

    // ---- 3: prog_full pulse with an empty skid ----
    for (int p = 0; p < 9; p++) begin
      cyc_begin();
      bus.fifo_prog_full = (p < 6);
      drive(1'b0, '0, 1'b0);
      cyc_end();
      check("t3_rdy", DW'(bus.in_rdy), DW'((p == 0) || (p >= 7)));
      check("t3_stall", DW'(stall_sts), DW'((p >= 1) && (p <= 6)));
    end

    // ---- 4: beat arriving at a full skid is dropped ----
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc_begin();
      drive(1'b1, DW'(32'h200 + i), 1'b1);
      cyc_end();
      check("t4_fill_cnt", DW'(skid_cnt), DW'(i));
    end
    cyc_begin();
    drive(1'b1, DW'(32'hDEAD), 1'b0);
    cyc_end();
    check("t4_full_cnt", DW'(skid_cnt), 8);
    cyc_begin();
    drive(1'b0, '0, 1'b0);
    exp_ovf = 1'b1;
    cyc_end();
    exp_ovf = 1'b0;
    check("t4_cnt_after_drop", DW'(skid_cnt), 8);
    for (int j = 0; j < 8; j++) begin
      cyc_begin();
      bus.fifo_full = 1'b0;
      drive(1'b0, '0, 1'b0);
      cyc_end();
      check("t4_drain_cnt", DW'(skid_cnt), DW'(8 - j));
      check("t4_drain_wr_en", DW'(bus.fifo_wr_en), 1);
    end
    idle();
    check("t4_empty_cnt", DW'(skid_cnt), '0);
    check("t4_sb_drained", DW'(exp_q.size()), '0);

    // ---- 5: flush with 6 beats in the skid, beats keep arriving ----
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc_begin();
      drive(1'b1, DW'(32'h300 + i), 1'b1);
      cyc_end();
    end
    cyc_begin();
    bus.fifo_full = 1'b0;
    flush = 1'b1;
    drive(1'b1, DW'(32'h3FF), 1'b0);
    cyc_end();
    check("t5_cnt_at_flush", DW'(skid_cnt), 6);
    exp_q.delete();
    for (int g = 0; g < 3; g++) begin
      cyc_begin();
      flush = 1'b0;
      drive(1'b1, DW'(32'h3A0 + g), 1'b0);
      cyc_end();
      check("t5_cnt", DW'(skid_cnt), '0);
      check("t5_wr_en", DW'(bus.fifo_wr_en), '0);
      check("t5_rdy", DW'(bus.in_rdy), '0);
      check("t5_stall", DW'(stall_sts), '0);
    end
    idle();
    check("t5_rdy_back", DW'(bus.in_rdy), 1);
    check("t5_cnt_after", DW'(skid_cnt), '0);

    // ---- 6: reset with 5 beats in the skid ----
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc_begin();
      drive(1'b1, DW'(32'h400 + i), 1'b1);
      cyc_end();
    end
    cyc_begin();
    check("t6_cnt_before", DW'(skid_cnt), 5);
    drive(1'b0, '0, 1'b0);
    bus.fifo_full = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    cyc_end();
    check("t6_rst_rdy", DW'(bus.in_rdy), '0);
    check("t6_rst_cnt", DW'(skid_cnt), '0);
    check("t6_rst_stall", DW'(stall_sts), '0);
    check("t6_rst_ovf", DW'(ovf_int), '0);
    cyc_begin();
    rst_n = 1'b1;
    cyc_end();
    check("t6_rdy_at_release", DW'(bus.in_rdy), '0);
    idle();
    check("t6_rdy_after_release", DW'(bus.in_rdy), 1);
    check("t6_cnt_after_release", DW'(skid_cnt), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_as6d_pcs_tx_pldb_wr_skid_ctrl
